// File: rtl/mac_unit_wave_seq.sv
// Self-sequencing bit-serial weight MAC: walks the non-zero weight bit-columns of
// each accepted vector MSB first and emits the accumulated group dot-product.
module mac_unit_wave_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int W_PREC     = 8,
   parameter int VEC_LENGTH = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  in_last,
   input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
   input  logic [VEC_LENGTH-1:0]                 w_sign,
   input  logic [VEC_LENGTH-1:0][W_PREC-2:0]     w_mag,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ACC_WIDTH-1:0]                  result
);

   localparam int MW = W_PREC - 1;
   localparam int PW = (MW > 1) ? $clog2(MW) : 1;
   localparam int TW = DATA_WIDTH + 1;
   localparam int SW = TW + $clog2(VEC_LENGTH);

   typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_e;

   state_e                                state_q, state_d;
   logic [ACC_WIDTH-1:0]                  acc_q, acc_d;
   logic [ACC_WIDTH-1:0]                  result_q, result_d;
   logic [MW-1:0]                         mask_q, mask_d;
   logic [PW-1:0]                         ptr_q, ptr_d;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
   logic [VEC_LENGTH-1:0]                 sign_q;
   logic [VEC_LENGTH-1:0][MW-1:0]         mag_q;
   logic                                  last_q;

   logic                 load;
   logic [MW-1:0]        in_mask;
   logic [MW-1:0]        rem_mask;
   logic [SW-1:0]        col_sum;
   logic [ACC_WIDTH-1:0] addend;
   logic [ACC_WIDTH-1:0] acc_sum;

   function automatic logic [PW-1:0] top_bit(input logic [MW-1:0] m);
      top_bit = '0;
      for (int c = 0; c < MW; c++)
         if (m[c]) top_bit = PW'(c);
   endfunction

   always_comb begin
      in_mask = '0;
      for (int l = 0; l < VEC_LENGTH; l++)
         in_mask = in_mask | w_mag[l];
   end

   // Sign-extend before negating so the most negative activation negates exactly.
   always_comb begin
      col_sum = '0;
      for (int l = 0; l < VEC_LENGTH; l++) begin
         logic [TW-1:0] ext;
         logic [TW-1:0] term;
         ext  = {act_q[l][DATA_WIDTH-1], act_q[l]};
         term = sign_q[l] ? -ext : ext;
         if (mag_q[l][ptr_q])
            col_sum = col_sum + {{(SW-TW){term[TW-1]}}, term};
      end
   end

   assign addend   = {{(ACC_WIDTH-SW){col_sum[SW-1]}}, col_sum} << ptr_q;
   assign acc_sum  = acc_q + addend;
   assign rem_mask = mask_q & ~(MW'(1) << ptr_q);

   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == OUTPUT);
   assign result    = result_q;

   // NOTE: every _d gets its current value first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      result_d = result_q;
      mask_d   = mask_q;
      ptr_d    = ptr_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               load    = 1'b1;
               mask_d  = in_mask;
               ptr_d   = top_bit(in_mask);
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            mask_d = rem_mask;
            ptr_d  = top_bit(rem_mask);
            acc_d  = acc_sum;
            if (rem_mask == '0) begin
               if (last_q) begin
                  result_d = acc_sum;
                  acc_d    = '0;
                  state_d  = OUTPUT;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         OUTPUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         result_q <= '0;
         mask_q   <= '0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         mask_q   <= mask_d;
         ptr_q    <= ptr_d;
      end
   end

   // NOTE: operand registers are only read after a load, so they carry no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         act_q  <= act;
         sign_q <= w_sign;
         mag_q  <= w_mag;
         last_q <= in_last;
      end
   end

endmodule

// File: tb/tb_mac_unit_wave_seq.sv
// Scoreboard bench for mac_unit_wave_seq: group results are queued on acceptance
// of the closing vector and compared when the output handshake completes.
module tb_mac_unit_wave_seq;

   localparam int DW = 8;
   localparam int WP = 8;
   localparam int VL = 8;
   localparam int AW = 24;
   localparam int MW = WP - 1;

   typedef logic [VL-1:0][DW-1:0] act_t;
   typedef logic [VL-1:0][MW-1:0] mag_t;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic          in_last   = 1'b0;
   act_t          act       = '0;
   logic [VL-1:0] w_sign    = '0;
   mag_t          w_mag     = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] result;

   int            n_vec     = 0;
   int            n_err     = 0;
   int            model_acc = 0;
   logic [AW-1:0] sb_q[$];

   always #5 clk = ~clk;

   mac_unit_wave_seq #(
      .DATA_WIDTH(DW), .W_PREC(WP), .VEC_LENGTH(VL), .ACC_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .act(act), .w_sign(w_sign), .w_mag(w_mag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic act_t act_all(input int v);
      act_t r;
      for (int l = 0; l < VL; l++) r[l] = DW'(v);
      return r;
   endfunction

   function automatic mag_t mag_all(input int v);
      mag_t r;
      for (int l = 0; l < VL; l++) r[l] = MW'(v);
      return r;
   endfunction

   function automatic int dot(input act_t a, input logic [VL-1:0] s, input mag_t m);
      int r = 0;
      for (int l = 0; l < VL; l++) begin
         int av = $signed(a[l]);
         int wv = s[l] ? -int'(m[l]) : int'(m[l]);
         r += av * wv;
      end
      return r;
   endfunction

   // Enter and leave one cycle after a rising edge; checks the column-count latency.
   task automatic send(input act_t a, input logic [VL-1:0] s, input mag_t m, input logic last);
      logic [MW-1:0] msk = '0;
      int n, k, t;
      for (int l = 0; l < VL; l++) msk |= m[l];
      n = ($countones(msk) == 0) ? 1 : $countones(msk);
      act = a; w_sign = s; w_mag = m; in_last = last; in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", 32'(t < 50), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_acc += dot(a, s, m);
      if (last) begin
         sb_q.push_back(AW'(model_acc));
         model_acc = 0;
      end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(last ? out_valid : in_ready) && k < 60);
      check(last ? "lat_out" : "lat_in", k, n + 1);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) check("spurious_out", 1, 0);
         else check("result", result, sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            seen;
      int            nv;
      act_t          ra;
      mag_t          rm;
      logic [MW-1:0] cm;

      reset = 1'b1; in_valid = 1'b1; act = act_all(1); w_mag = mag_all(1); in_last = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_result", result, 0);
      end
      @(posedge clk);
      #1 reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      send(act_all(1), '0, mag_all(1), 1'b1);
      send(act_all(3), '0, mag_all(7'b1000001), 1'b1);
      send(act_all(-128), '1, mag_all(127), 1'b1);
      send(act_all(-128), '1, mag_all(0), 1'b1);

      send(act_all(2), '0, mag_all(5), 1'b0);
      send(act_all(2), '0, mag_all(5), 1'b0);
      out_ready = 1'b0;
      send(act_all(2), '1, mag_all(5), 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_hold", result, 80);
         check("bp_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_idle_ready", in_ready, 1);
      check("bp_valid_drop", out_valid, 0);
      @(posedge clk);
      #1;

      for (int g = 0; g < 5; g++) begin
         nv = $urandom_range(1, 3);
         for (int v = 0; v < nv; v++) begin
            cm = (g == 0) ? '0 : MW'($urandom);
            for (int l = 0; l < VL; l++) begin
               ra[l] = DW'($urandom);
               rm[l] = MW'($urandom) & cm;
            end
            send(ra, VL'($urandom), rm, v == nv - 1);
         end
      end

      send(act_all(5), '0, mag_all(3), 1'b0);
      act = act_all(7); w_sign = '0; w_mag = mag_all(127); in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("abort_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_acc = 0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_out", seen, 0);
      @(posedge clk);
      #1;
      send(act_all(1), '0, mag_all(1), 1'b1);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
